// File: rtl/frame_responder.sv
// Far-end endpoint of the inter-domain frame link: checks CRC-32 and the type/sequence rules of a
// forwarded frame, answers with OKAY/ERROR/FATAL_ERROR and releases the payload on OKAY.
module frame_responder #(
   parameter int unsigned DATA_SIZE     = 64,
   parameter int unsigned PREAMBLE_SIZE = 7,
   parameter int unsigned CRC_SIZE      = 4,
   parameter int unsigned FRAME_SIZE    = (PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE) * 8 - 1,
   parameter logic [31:0] CRC_POLY      = 32'h04C11DB7,
   parameter int unsigned MAX_RETRY     = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [0:FRAME_SIZE]     frame_in,
   input  logic                    frame_in_valid,
   output logic [7:0]              confirm_code,
   output logic                    confirm_valid,
   output logic [0:DATA_SIZE*8-1]  data_out,
   output logic                    data_out_valid,
   output logic                    session_active,
   output logic [31:0]             last_frame_nr,
   output logic                    busy
);

   localparam int unsigned FRAME_BYTES = PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE;
   localparam int unsigned IDX_W       = $clog2(FRAME_BYTES);
   localparam int unsigned RETRY_W     = $clog2(MAX_RETRY + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

   localparam logic [7:0] CODE_OKAY  = 8'h05;
   localparam logic [7:0] CODE_ERROR = 8'h04;
   localparam logic [7:0] CODE_FATAL = 8'h08;

   localparam logic [7:0] TYPE_FIRST  = 8'h00;
   localparam logic [7:0] TYPE_LAST   = 8'h01;
   localparam logic [7:0] TYPE_NORMAL = 8'h02;
   localparam logic [7:0] TYPE_SINGLE = 8'h03;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CRC,
      S_CHECK,
      S_WAIT_LOW
   } state_t;

   state_t               state;
   logic [0:FRAME_SIZE]  frame_q;
   logic [31:0]          crc;
   logic [IDX_W-1:0]     byte_idx;
   logic [RETRY_W-1:0]   retry_cnt;

   logic [7:0]           cur_byte;
   logic [31:0]          crc_next;
   logic [7:0]           frame_type;
   logic [31:0]          frame_nr;
   logic                 nr_seq;
   logic                 type_ok;
   logic                 frame_ok;
   logic                 retry_last;

   // Shift one byte, MSB first, through the non-reflected CRC-32 register.
   function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
      logic [31:0] c;
      c = c_in;
      for (int i = 7; i >= 0; i--) begin
         if (c[31] ^ b[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
         else              c = {c[30:0], 1'b0};
      end
      return c;
   endfunction

   assign frame_type = frame_q[0:7];
   assign frame_nr   = frame_q[24:55];

   // Byte under the CRC walk and its contribution to the remainder.
   always_comb begin
      cur_byte = frame_q[{byte_idx, 3'b000} +: 8];
      crc_next = crc_byte(crc, cur_byte);
   end

   // Verdict: type/sequence rules against session state, plus a zero CRC remainder.
   always_comb begin
      type_ok = 1'b0;
      nr_seq  = (frame_nr == last_frame_nr + 32'd1);
      case (frame_type)
         TYPE_FIRST:             type_ok = !session_active;
         TYPE_NORMAL, TYPE_LAST: type_ok = session_active && nr_seq;
         TYPE_SINGLE:            type_ok = !session_active;
         default:                type_ok = 1'b0;
      endcase
      frame_ok   = type_ok && (crc == 32'd0);
      retry_last = (32'(retry_cnt) + 32'd1) >= MAX_RETRY;
   end

   // Capture / CRC walk / verdict / wait-for-release sequencer with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         frame_q        <= '0;
         crc            <= '0;
         byte_idx       <= '0;
         retry_cnt      <= '0;
         confirm_code   <= '0;
         confirm_valid  <= 1'b0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         session_active <= 1'b0;
         last_frame_nr  <= '0;
         busy           <= 1'b0;
      end else begin
         confirm_valid  <= 1'b0;
         data_out_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (frame_in_valid) begin
                  frame_q  <= frame_in;
                  crc      <= '0;
                  byte_idx <= '0;
                  busy     <= 1'b1;
                  state    <= S_CRC;
               end
            end
            S_CRC: begin
               crc      <= crc_next;
               byte_idx <= byte_idx + IDX_W'(1);
               if (byte_idx == LAST_IDX) state <= S_CHECK;
            end
            S_CHECK: begin
               confirm_valid <= 1'b1;
               if (frame_ok) begin
                  confirm_code   <= CODE_OKAY;
                  data_out       <= frame_q[PREAMBLE_SIZE*8 +: DATA_SIZE*8];
                  data_out_valid <= 1'b1;
                  retry_cnt      <= '0;
                  state          <= S_WAIT_LOW;
                  case (frame_type)
                     TYPE_FIRST: begin
                        session_active <= 1'b1;
                        last_frame_nr  <= frame_nr;
                     end
                     TYPE_NORMAL: last_frame_nr <= frame_nr;
                     TYPE_LAST: begin
                        session_active <= 1'b0;
                        last_frame_nr  <= '0;
                     end
                     default: ;
                  endcase
               end else if (retry_last) begin
                  confirm_code   <= CODE_FATAL;
                  retry_cnt      <= '0;
                  session_active <= 1'b0;
                  last_frame_nr  <= '0;
                  state          <= S_WAIT_LOW;
               end else begin
                  // Back to IDLE so a retransmission still held on the link is re-captured.
                  confirm_code <= CODE_ERROR;
                  retry_cnt    <= retry_cnt + RETRY_W'(1);
                  busy         <= 1'b0;
                  state        <= S_IDLE;
               end
            end
            S_WAIT_LOW: begin
               if (!frame_in_valid) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_responder.sv
// Scoreboard bench for frame_responder: a reference model predicts each confirm when a frame
// is driven; predictions are popped and compared when the confirm strobe appears.
module tb_frame_responder;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [0:599]   frame_in = '0;
   logic           frame_in_valid = 1'b0;
   logic [7:0]     confirm_code;
   logic           confirm_valid;
   logic [0:511]   data_out;
   logic           data_out_valid;
   logic           session_active;
   logic [31:0]    last_frame_nr;
   logic           busy;

   frame_responder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .frame_in       (frame_in),
      .frame_in_valid (frame_in_valid),
      .confirm_code   (confirm_code),
      .confirm_valid  (confirm_valid),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .session_active (session_active),
      .last_frame_nr  (last_frame_nr),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]   code;
      logic         sess;
      logic [31:0]  last;
      logic [0:511] data;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          failures = 0;
   logic        m_sess = 1'b0;
   logic [31:0] m_last = '0;
   int          m_retry = 0;

   // Single comparison point: counts every check and reports mismatches.
   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference CRC-32, MSB first, zero init, no reflection, no final XOR.
   function automatic logic [31:0] crc_calc(input logic [0:599] f, input int nbytes);
      logic [31:0] c;
      logic [7:0]  b;
      c = '0;
      for (int k = 0; k < nbytes; k++) begin
         b = f[8*k +: 8];
         for (int j = 7; j >= 0; j--) begin
            if (c[31] ^ b[j]) c = {c[30:0], 1'b0} ^ 32'h04C11DB7;
            else              c = {c[30:0], 1'b0};
         end
      end
      return c;
   endfunction

   function automatic logic [0:599] make_frame(input logic [7:0] typ, input logic [31:0] nr,
                                               input int seed, input bit corrupt);
      logic [0:599] f;
      f = '0;
      f[0:7]   = typ;
      f[24:55] = nr;
      for (int k = 7; k <= 70; k++) f[8*k +: 8] = 8'(seed * 7 + k * 13);
      f[568:599] = crc_calc(f, 71);
      if (corrupt) f[300] = ~f[300];
      return f;
   endfunction

   // Reference model of one verdict; updates the model session/retry state.
   task automatic model(input logic [7:0] typ, input logic [31:0] nr, input bit crc_ok,
                        input logic [0:511] pl, output exp_t e);
      bit ok;
      case (typ)
         8'h00:        ok = !m_sess;
         8'h01, 8'h02: ok = m_sess && (nr == m_last + 32'd1);
         8'h03:        ok = !m_sess;
         default:      ok = 1'b0;
      endcase
      ok = ok && crc_ok;
      e.data = pl;
      if (ok) begin
         e.code = 8'h05;
         m_retry = 0;
         if (typ == 8'h00) begin m_sess = 1'b1; m_last = nr; end
         else if (typ == 8'h02) m_last = nr;
         else if (typ == 8'h01) begin m_sess = 1'b0; m_last = '0; end
      end else if (m_retry + 1 < 3) begin
         e.code = 8'h04;
         m_retry++;
      end else begin
         e.code = 8'h08;
         m_retry = 0;
         m_sess = 1'b0;
         m_last = '0;
      end
      e.sess = m_sess;
      e.last = m_last;
   endtask

   // Wait (bounded) for the confirm strobe, then pop the prediction and compare.
   task automatic wait_confirm();
      int   lat;
      exp_t e;
      lat = -1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (confirm_valid) begin
            lat = i;
            break;
         end
      end
      e = sb_q.pop_front();
      check("confirm_seen", 512'(lat >= 0), 512'(1));
      if (lat < 0) return;
      check("latency", 512'(lat), 512'(76));
      check("code", 512'(confirm_code), 512'(e.code));
      check("session_active", 512'(session_active), 512'(e.sess));
      check("last_frame_nr", 512'(last_frame_nr), 512'(e.last));
      check("data_out_valid", 512'(data_out_valid), 512'(e.code == 8'h05));
      if (e.code == 8'h05) check("data_out", 512'(data_out), 512'(e.data));
   endtask

   // Drive a frame and hold valid across `attempts` confirms, then release the link.
   task automatic send(input logic [7:0] typ, input logic [31:0] nr, input int seed,
                       input bit corrupt, input int attempts);
      logic [0:599] f;
      exp_t         e;
      f = make_frame(typ, nr, seed, corrupt);
      frame_in = f;
      frame_in_valid = 1'b1;
      e = '0;
      for (int a = 0; a < attempts; a++) begin
         model(typ, nr, !corrupt, f[56:567], e);
         sb_q.push_back(e);
         wait_confirm();
      end
      frame_in_valid = 1'b0;
      @(posedge clk); #1;
      check("strobe_drop", 512'(confirm_valid), 512'(0));
      check("code_hold", 512'(confirm_code), 512'(e.code));
      check("busy_idle", 512'(busy), 512'(0));
   endtask

   initial begin
      bit seen;
      #1;
      check("rst_confirm_valid", 512'(confirm_valid), 512'(0));
      check("rst_confirm_code", 512'(confirm_code), 512'(0));
      check("rst_busy", 512'(busy), 512'(0));
      check("rst_session", 512'(session_active), 512'(0));
      check("rst_last_nr", 512'(last_frame_nr), 512'(0));
      check("rst_data_valid", 512'(data_out_valid), 512'(0));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Session open, in-sequence, out-of-sequence, then recovery.
      send(8'h00, 32'd5, 1, 1'b0, 1);
      send(8'h02, 32'd6, 2, 1'b0, 1);
      send(8'h02, 32'd8, 3, 1'b0, 1);
      send(8'h02, 32'd7, 4, 1'b0, 1);

      // Corrupted frame held high: two ERRORs then FATAL_ERROR.
      send(8'h02, 32'd8, 5, 1'b1, 3);

      // SINGLE inside and outside a session, LAST closing, reopen, unknown type.
      send(8'h00, 32'd10, 6, 1'b0, 1);
      send(8'h03, 32'd20, 7, 1'b0, 1);
      send(8'h01, 32'd11, 8, 1'b0, 1);
      send(8'h03, 32'd30, 9, 1'b0, 1);
      send(8'h00, 32'd100, 10, 1'b0, 1);
      send(8'h07, 32'd101, 11, 1'b0, 1);

      // Reset in the middle of a CRC walk.
      frame_in = make_frame(8'h02, 32'd101, 12, 1'b0);
      frame_in_valid = 1'b1;
      repeat (41) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_busy", 512'(busy), 512'(0));
      check("abort_session", 512'(session_active), 512'(0));
      check("abort_last_nr", 512'(last_frame_nr), 512'(0));
      check("abort_code", 512'(confirm_code), 512'(0));
      check("abort_confirm_valid", 512'(confirm_valid), 512'(0));
      frame_in_valid = 1'b0;
      m_sess = 1'b0;
      m_last = '0;
      m_retry = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (confirm_valid) seen = 1'b1;
      end
      check("abort_no_confirm", 512'(seen), 512'(0));

      // Sequence number wrap and a wrong LAST number.
      send(8'h00, 32'hFFFF_FFFF, 13, 1'b0, 1);
      send(8'h02, 32'd0, 14, 1'b0, 1);
      send(8'h01, 32'd5, 15, 1'b0, 1);
      send(8'h01, 32'd1, 16, 1'b0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
